// File: rtl/hiscore_upload_reader.sv
// HPS upload source for game work RAM (hiscore / NVRAM saves): pauses the CPU, then serves one RAM byte per ioctl_rd.
// Optional HISCORE_UPLOAD_CHECKSUM_EN appends a two's-complement checksum byte at address SIZE.
module hiscore_upload_reader #(
   parameter logic [7:0] UPLOAD_INDEX = 8'd4,
   parameter int         AW           = 10,
   parameter int         SIZE         = 1024,
   parameter int         RAM_LATENCY  = 1,
   parameter logic [7:0] FILL         = 8'hFF,
   parameter int         SETTLE       = 4
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ioctl_upload,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic          pause_req,
   input  logic          pause_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rd,
   input  logic [7:0]    ram_dout,
   output logic          busy
);

   localparam int SCW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;

   state_t          state, state_d;
   logic            sel, sel_q;
   logic [SCW-1:0]  settle_cnt, settle_d;
   logic [1:0]      lat_cnt, lat_d;
   logic            pend, pend_d;
   logic [24:0]     pend_addr, pend_addr_d;
   logic [7:0]      din_d;
   logic            wait_d, preq_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic            trig, in_ram;
   logic [24:0]     req_addr;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
   logic [7:0]      sum, sum_d;
`endif

   // pend marks an outstanding request: a strobe latched while paused, or a fetch
   // that was issued and must be re-issued if the pause is lost before delivery.
   assign sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
   assign trig     = pend || ioctl_rd;
   assign req_addr = pend ? pend_addr : ioctl_addr;
   assign in_ram   = req_addr < 25'(SIZE);
   assign busy     = (state != IDLE);
   assign ram_addr = ram_addr_d;

   always_comb begin
      state_d     = state;
      settle_d    = settle_cnt;
      lat_d       = lat_cnt;
      pend_d      = pend;
      pend_addr_d = pend_addr;
      din_d       = ioctl_din;
      wait_d      = ioctl_wait;
      preq_d      = pause_req;
      ram_addr_d  = ram_addr_q;
      ram_rd      = 1'b0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_d       = sum;
`endif
      case (state)
         IDLE: begin
            if (sel && !sel_q) begin
               state_d     = PAUSE;
               preq_d      = 1'b1;
               wait_d      = 1'b1;
               settle_d    = '0;
               pend_d      = ioctl_rd;
               pend_addr_d = ioctl_addr;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
               sum_d       = 8'h00;
`endif
            end
         end
         PAUSE: begin
            if (ioctl_rd && !pend) begin
               pend_d      = 1'b1;
               pend_addr_d = ioctl_addr;
            end
            if (!pause_ack) begin
               settle_d = '0;
            end else if (settle_cnt == SCW'(SETTLE - 1)) begin
               state_d  = READY;
               wait_d   = 1'b0;
               settle_d = '0;
            end else begin
               settle_d = settle_cnt + 1'b1;
            end
         end
         READY: begin
            if (!pause_ack) begin
               state_d  = PAUSE;
               wait_d   = 1'b1;
               settle_d = '0;
               if (ioctl_rd && !pend) begin
                  pend_d      = 1'b1;
                  pend_addr_d = ioctl_addr;
               end
            end else if (trig) begin
               if (in_ram) begin
                  ram_rd      = 1'b1;
                  ram_addr_d  = req_addr[AW-1:0];
                  wait_d      = 1'b1;
                  lat_d       = 2'd0;
                  pend_d      = 1'b1;
                  pend_addr_d = req_addr;
                  state_d     = FETCH;
               end else begin
                  pend_d = 1'b0;
                  din_d  = FILL;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
                  if (req_addr == 25'(SIZE)) din_d = ~sum + 8'd1;
`endif
               end
            end
         end
         FETCH: begin
            if (!pause_ack) begin
               state_d  = PAUSE;
               wait_d   = 1'b1;
               settle_d = '0;
            end else if (lat_cnt == 2'(RAM_LATENCY)) begin
               din_d   = ram_dout;
               wait_d  = 1'b0;
               pend_d  = 1'b0;
               state_d = READY;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
               sum_d   = sum + ram_dout;
`endif
            end else begin
               lat_d = lat_cnt + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Session end overrides everything, including a strobe in the same clock.
      if (!sel && state != IDLE) begin
         state_d  = IDLE;
         preq_d   = 1'b0;
         wait_d   = 1'b0;
         pend_d   = 1'b0;
         settle_d = '0;
         ram_rd   = 1'b0;
         din_d    = ioctl_din;
         ram_addr_d = ram_addr_q;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sel_q      <= 1'b0;
         settle_cnt <= '0;
         lat_cnt    <= 2'd0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         ioctl_din  <= 8'h00;
         ioctl_wait <= 1'b0;
         pause_req  <= 1'b0;
         ram_addr_q <= '0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
         sum        <= 8'h00;
`endif
      end else begin
         state      <= state_d;
         sel_q      <= sel;
         settle_cnt <= settle_d;
         lat_cnt    <= lat_d;
         pend       <= pend_d;
         pend_addr  <= pend_addr_d;
         ioctl_din  <= din_d;
         ioctl_wait <= wait_d;
         pause_req  <= preq_d;
         ram_addr_q <= ram_addr_d;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
         sum        <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_hiscore_upload_reader.sv
// Directed + randomized bench for hiscore_upload_reader against a byte-level reference model.
module tb_hiscore_upload_reader;
   localparam int         AW     = 10;
   localparam int         SIZE   = 1024;
   localparam int         L      = 2;
   localparam int         SETTLE = 4;
   localparam logic [7:0] FILL   = 8'hFF;
   localparam logic [7:0] IDX    = 8'd4;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic          ioctl_upload = 1'b0;
   logic [7:0]    ioctl_index = 8'd0;
   logic          ioctl_rd = 1'b0;
   logic [24:0]   ioctl_addr = '0;
   logic          pause_ack = 1'b0;
   logic [7:0]    ioctl_din;
   logic          ioctl_wait, pause_req, ram_rd, busy;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_dout;

   int checks = 0, errors = 0, rd_pulses = 0, rd_viol = 0;
   logic [7:0] mem [0:SIZE-1];
   logic [7:0] m_sum = 8'h00;
   logic [7:0] st1 = 8'h00, st2 = 8'h00;

   hiscore_upload_reader #(.UPLOAD_INDEX(IDX), .AW(AW), .SIZE(SIZE), .RAM_LATENCY(L),
                           .FILL(FILL), .SETTLE(SETTLE)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
      .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_req(pause_req),
      .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
      .ram_dout(ram_dout), .busy(busy));

   always #5 clk_sys = ~clk_sys;

   // RAM with L registered stages after the read strobe
   always @(posedge clk_sys) begin
      if (ram_rd) st1 <= mem[ram_addr];
      st2 <= st1;
   end
   assign ram_dout = st2;

   always @(posedge clk_sys) begin
      if (ram_rd) rd_pulses <= rd_pulses + 1;
      if (ram_rd && !pause_ack) rd_viol <= rd_viol + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [24:0] a);
      if (a < 25'(SIZE)) return mem[a[AW-1:0]];
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      if (a == 25'(SIZE)) return ~m_sum + 8'd1;
`endif
      return FILL;
   endfunction

   // called on a falling edge; one strobe, then wait out the stall
   task automatic do_read(input logic [24:0] a);
      logic [7:0] exp;
      logic       inr;
      int         n, p0;
      inr = (a < 25'(SIZE));
      exp = model_byte(a);
      p0  = rd_pulses;
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      n = 0;
      while (ioctl_wait && n < 50) begin
         n++;
         @(negedge clk_sys);
      end
      chk("wait_clks", 32'(n), inr ? 32'(L + 1) : 32'd0);
      chk("din", 32'(ioctl_din), 32'(exp));
      chk("ram_rd_pulses", 32'(rd_pulses - p0), inr ? 32'd1 : 32'd0);
      if (inr) m_sum = m_sum + mem[a[AW-1:0]];
   endtask

   task automatic start_session();
      int n;
      ioctl_index  = IDX;
      ioctl_upload = 1'b1;
      pause_ack    = 1'b1;
      m_sum        = 8'h00;
      @(negedge clk_sys);
      n = 0;
      while (ioctl_wait && n < 100) begin
         n++;
         @(negedge clk_sys);
      end
      chk("session_settle", 32'(n), 32'(SETTLE));
   endtask

   task automatic end_session();
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_pause_req", 32'(pause_req), 32'd0);
   endtask

   initial begin
      int n, p0;
      logic [24:0] ra;
      logic [7:0]  held;
      for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);

      // reset values
      repeat (3) @(negedge clk_sys);
      chk("rst_din", 32'(ioctl_din), 32'd0);
      chk("rst_wait", 32'(ioctl_wait), 32'd0);
      chk("rst_pause_req", 32'(pause_req), 32'd0);
      chk("rst_ram_rd", 32'(ram_rd), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // asynchronous reset in the middle of PAUSE
      ioctl_index  = IDX;
      ioctl_upload = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("pause_req_up", 32'(pause_req), 32'd1);
      chk("pause_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_pause_req", 32'(pause_req), 32'd0);
      chk("async_wait", 32'(ioctl_wait), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_din", 32'(ioctl_din), 32'd0);
      @(negedge clk_sys);
      ioctl_upload = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // session start, ack 2 clocks late, strobe latched while paused
      mem[0] = 8'hA5;
      pause_ack    = 1'b0;
      ioctl_upload = 1'b1;
      m_sum        = 8'h00;
      @(negedge clk_sys);
      chk("start_wait", 32'(ioctl_wait), 32'd1);
      p0 = rd_pulses;
      n = 0;
      do begin
         n++;
         if (n == 1) begin ioctl_addr = '0; ioctl_rd = 1'b1; end
         if (n == 2) ioctl_rd = 1'b0;
         if (n == 3) pause_ack = 1'b1;
         @(negedge clk_sys);
      end while (ioctl_wait && n < 100);
      chk("pause_wait_clks", 32'(n), 32'(2 + SETTLE));
      n = 0;
      while (!ioctl_wait && n < 10) begin n++; @(negedge clk_sys); end
      n = 0;
      while (ioctl_wait && n < 50) begin n++; @(negedge clk_sys); end
      chk("pending_din", 32'(ioctl_din), 32'hA5);
      chk("pending_pulses", 32'(rd_pulses - p0), 32'd1);
      m_sum = m_sum + 8'hA5;
      mem[0] = 8'h00;

      // full sequential sweep
      for (int i = 0; i < SIZE; i++) do_read(25'(i));

      // out of range
      do_read(25'(SIZE));
      do_read(25'h1FFFFFF);

      // pause lost during a fetch at 37
      held = ioctl_din;
      p0 = rd_pulses;
      ioctl_addr = 25'd37;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd  = 1'b0;
      pause_ack = 1'b0;
      @(negedge clk_sys);
      chk("ackdrop_wait", 32'(ioctl_wait), 32'd1);
      repeat (3) @(negedge clk_sys);
      chk("ackdrop_wait_hold", 32'(ioctl_wait), 32'd1);
      chk("ackdrop_din_hold", 32'(ioctl_din), 32'(held));
      pause_ack = 1'b1;
      repeat (SETTLE + L + 10) @(negedge clk_sys);
      chk("reissue_din", 32'(ioctl_din), 32'(mem[37]));
      chk("reissue_wait", 32'(ioctl_wait), 32'd0);
      chk("reissue_pulses", 32'(rd_pulses - p0), 32'd2);
      m_sum = m_sum + mem[37];

      // session end abandons a fetch
      held = ioctl_din;
      ioctl_addr = 25'd5;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      end_session();
      chk("abandon_wait", 32'(ioctl_wait), 32'd0);
      repeat (4) @(negedge clk_sys);
      chk("abandon_din", 32'(ioctl_din), 32'(held));

      // randomized reads
      for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
      start_session();
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    ra = 25'($urandom_range(0, SIZE - 1));
            2:       ra = 25'(SIZE + $urandom_range(0, 3));
            default: ra = 25'($urandom) | 25'h0400000;
         endcase
         do_read(ra);
      end
      end_session();

      // checksum byte, all ones then RAM[0]=2
      for (int i = 0; i < SIZE; i++) mem[i] = 8'h01;
      start_session();
      for (int i = 0; i <= SIZE; i++) do_read(25'(i));
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      chk("checksum_ones", 32'(ioctl_din), 32'h00);
`else
      chk("checksum_ones", 32'(ioctl_din), 32'hFF);
`endif
      end_session();
      mem[0] = 8'h02;
      start_session();
      for (int i = 0; i <= SIZE; i++) do_read(25'(i));
      chk("checksum_two", 32'(ioctl_din), 32'hFF);
      end_session();

      chk("ram_rd_without_ack", 32'(rd_viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
